// File: rtl/adc_scan_sequencer_if.sv
// ADC capture handshake bundle: the sequencer drives the request and ack, and
// the capture block returns ready/data.
interface adc_scan_sequencer_if;
   logic        ctl_valid;
   logic [2:0]  address;
   logic        adc_ack;
   logic        adc_ready;
   logic [11:0] d_signal;

   modport master (output ctl_valid, output address, output adc_ack,
                   input adc_ready, input d_signal);
   modport slave  (input ctl_valid, input address, input adc_ack,
                   output adc_ready, output d_signal);
endinterface

// File: rtl/adc_scan_sequencer.sv
// Periodic ascending scan of masked ADC channels, with per-channel result registers,
// a conversion timeout and sticky overrun detection.
module adc_scan_sequencer #(
   parameter int unsigned clk_hz         = 25000000,
   parameter int unsigned scan_hz        = 1000,
   parameter int unsigned timeout_cycles = 4096
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic [7:0]                  ch_mask,
   adc_scan_sequencer_if.master        adc,
   input  logic [2:0]                  rd_addr,
   output logic [11:0]                 rd_data,
   output logic [7:0]                  sample_valid,
   output logic                        scan_done,
   output logic                        timeout_err,
   output logic                        overrun
);
   localparam int unsigned P  = clk_hz / scan_hz;
   localparam int unsigned CW = (P > 1) ? $clog2(P) : 1;
   localparam int unsigned WW = $clog2(timeout_cycles + 1);
   localparam logic [CW-1:0] TICK_AT   = CW'(P - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(timeout_cycles - 1);

   typedef enum logic [2:0] {IDLE, SETUP, CONVERT, RELEASE, NEXT} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      tcnt_q, tcnt_d;
   logic [WW-1:0]      wait_q, wait_d;
   logic [7:0]         scan_mask_q, scan_mask_d;
   logic [2:0]         address_q, address_d;
   logic               adc_ack_q, adc_ack_d;
   logic               timeout_err_q, timeout_err_d;
   logic               overrun_q, overrun_d;
   logic [7:0]         sample_valid_q, sample_valid_d;
   logic [7:0][11:0]   result_q, result_d;
   logic               tick;
   logic [7:0]         higher;

   function automatic logic [2:0] lowest(input logic [7:0] m);
      lowest = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (m[i]) lowest = 3'(i);
   endfunction

   always_comb begin
      tick           = (tcnt_q == TICK_AT);
      tcnt_d         = tick ? '0 : tcnt_q + 1'b1;
      higher         = scan_mask_q & (8'hFE << address_q);
      state_d        = state_q;
      wait_d         = '0;
      scan_mask_d    = scan_mask_q;
      address_d      = address_q;
      adc_ack_d      = 1'b0;
      timeout_err_d  = 1'b0;
      result_d       = result_q;
      scan_done      = 1'b0;
      // A tick outside IDLE means the scan overran its period; it is dropped.
      overrun_d      = overrun_q | (tick && state_q != IDLE);
      sample_valid_d = sample_valid_q;
      if (adc_ack_q) sample_valid_d[address_q] = 1'b1;

      case (state_q)
         IDLE: begin
            if (tick && enable && ch_mask != 8'd0) begin
               scan_mask_d = ch_mask;
               address_d   = lowest(ch_mask);
               state_d     = SETUP;
            end
         end
         SETUP: state_d = CONVERT;
         CONVERT: begin
            wait_d = wait_q + 1'b1;
            if (adc.adc_ready) begin
               result_d[address_q] = adc.d_signal;
               adc_ack_d           = 1'b1;
               state_d             = RELEASE;
            end else if (wait_q == WAIT_LAST) begin
               sample_valid_d[address_q] = 1'b0;
               timeout_err_d             = 1'b1;
               state_d                   = NEXT;
            end
         end
         RELEASE: begin
            if (!adc.adc_ready) state_d = NEXT;
         end
         NEXT: begin
            if (higher == 8'd0) begin
               scan_done = 1'b1;
               state_d   = IDLE;
            end else if (enable) begin
               address_d = lowest(higher);
               state_d   = SETUP;
            end else begin
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         tcnt_q         <= '0;
         wait_q         <= '0;
         scan_mask_q    <= '0;
         address_q      <= '0;
         adc_ack_q      <= 1'b0;
         timeout_err_q  <= 1'b0;
         overrun_q      <= 1'b0;
         sample_valid_q <= '0;
         result_q       <= '0;
      end else begin
         state_q        <= state_d;
         tcnt_q         <= tcnt_d;
         wait_q         <= wait_d;
         scan_mask_q    <= scan_mask_d;
         address_q      <= address_d;
         adc_ack_q      <= adc_ack_d;
         timeout_err_q  <= timeout_err_d;
         overrun_q      <= overrun_d;
         sample_valid_q <= sample_valid_d;
         result_q       <= result_d;
      end
   end

   // ctl_valid decodes straight from state so an async reset drops it at once.
   assign adc.ctl_valid = (state_q == CONVERT);
   assign adc.address   = address_q;
   assign adc.adc_ack   = adc_ack_q;
   assign rd_data       = result_q[rd_addr];
   assign sample_valid  = sample_valid_q;
   assign timeout_err   = timeout_err_q;
   assign overrun       = overrun_q;
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed scenarios with randomized ADC latency/data, checked against a
// transaction-level model of scan order, results and valid bits.
module tb_adc_scan_sequencer;
   localparam int P  = 100;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [7:0]  ch_mask = 8'd0;
   logic [2:0]  rd_addr = 3'd0;
   logic [11:0] rd_data;
   logic [7:0]  sample_valid;
   logic        scan_done, timeout_err, overrun;

   adc_scan_sequencer_if adc();

   adc_scan_sequencer #(.clk_hz(P * 1000), .scan_hz(1000), .timeout_cycles(TO)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask), .adc(adc),
      .rd_addr(rd_addr), .rd_data(rd_data), .sample_valid(sample_valid),
      .scan_done(scan_done), .timeout_err(timeout_err), .overrun(overrun));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ADC capture model: answers after a random latency, holds data until ack.
   int          lat_lo = 10, lat_hi = 10;
   logic [7:0]  mute = 8'd0;
   logic [11:0] golden [8];
   int          mst, mcnt;
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mst = 0; adc.adc_ready = 1'b0; adc.d_signal = 12'd0;
      end else begin
         case (mst)
            0: if (adc.ctl_valid && !mute[adc.address]) begin
                  mcnt = int'($urandom_range(lat_hi, lat_lo)); mst = 1;
               end
            1: if (!adc.ctl_valid) mst = 0;
               else begin
                  mcnt--;
                  if (mcnt <= 0) begin
                     adc.d_signal = 12'($urandom);
                     golden[adc.address] = adc.d_signal;
                     adc.adc_ready = 1'b1; mst = 2;
                  end
               end
            default: if (adc.adc_ack) begin adc.adc_ready = 1'b0; mst = 0; end
         endcase
      end
   end

   // Bus monitor; cleared whenever clr_gen moves.
   logic [2:0] addr_q[$];
   int         done_q[$];
   int ack_cnt, dbl_ack, done_cnt, to_cnt, to_len, to_cv, addr_chg, min_gap;
   int rise_cyc, fall_cyc, clr_gen = 0, seen_gen = 0;
   bit has_fall, pcv, pack;
   logic [2:0] paddr;
   always @(negedge clk) begin
      if (clr_gen != seen_gen) begin
         seen_gen = clr_gen; addr_q.delete(); done_q.delete();
         ack_cnt = 0; dbl_ack = 0; done_cnt = 0; to_cnt = 0; to_len = -1; to_cv = -1;
         addr_chg = 0; min_gap = 1000; has_fall = 0;
      end
      if (rst_n) begin
         if (adc.ctl_valid && !pcv) begin
            addr_q.push_back(adc.address); rise_cyc = cyc;
            if (has_fall && cyc - fall_cyc < min_gap) min_gap = cyc - fall_cyc;
         end
         if (!adc.ctl_valid && pcv) begin fall_cyc = cyc; has_fall = 1; end
         if (adc.ctl_valid && pcv && adc.address != paddr) addr_chg++;
         if (adc.adc_ack) begin ack_cnt++; if (pack) dbl_ack++; end
         if (timeout_err) begin to_cnt++; to_len = cyc - rise_cyc; to_cv = int'(adc.ctl_valid); end
         if (scan_done) begin done_cnt++; done_q.push_back(cyc); end
      end
      pcv = adc.ctl_valid; pack = adc.adc_ack; paddr = adc.address;
   end

   int vectors = 0, miscompares = 0;
   logic [7:0] exp_sv = 8'd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tk(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic clr();
      clr_gen++; tk(1);
   endtask

   task automatic quiet();
      enable = 1'b0; tk(250);
   endtask

   task automatic wait_done(input int target, input int budget);
      for (int i = 0; i < budget && done_cnt < target; i++) tk(1);
      check("wait_scan_done", 32'(done_cnt >= target), 32'd1);
   endtask

   task automatic wait_cv(input logic [2:0] a, input int budget);
      for (int i = 0; i < budget && !(adc.ctl_valid && adc.address == a); i++) tk(1);
      check("wait_ctl_valid", 32'(adc.ctl_valid && adc.address == a), 32'd1);
   endtask

   // Expected channel order is simply the set bits of the mask, low to high.
   task automatic check_seq(input string tag, input logic [7:0] m);
      logic [2:0] e[$];
      for (int i = 0; i < 8; i++) if (m[i]) e.push_back(3'(i));
      check({tag, "_count"}, 32'(addr_q.size() >= e.size()), 32'd1);
      for (int k = 0; k < e.size() && k < addr_q.size(); k++)
         check({tag, "_addr"}, 32'(addr_q[k]), 32'(e[k]));
   endtask

   task automatic check_results(input string tag, input logic [7:0] m);
      for (int i = 0; i < 8; i++)
         if (m[i]) begin
            rd_addr = 3'(i); #1;
            check(tag, 32'(rd_data), 32'(golden[i]));
         end
   endtask

   initial begin
      tk(3);
      check("rst_ctl_valid", 32'(adc.ctl_valid), 0);
      check("rst_address", 32'(adc.address), 0);
      check("rst_adc_ack", 32'(adc.adc_ack), 0);
      check("rst_scan_done", 32'(scan_done), 0);
      check("rst_timeout_err", 32'(timeout_err), 0);
      check("rst_overrun", 32'(overrun), 0);
      check("rst_sample_valid", 32'(sample_valid), 0);
      for (int i = 0; i < 8; i++) begin
         rd_addr = 3'(i); #1;
         check("rst_result", 32'(rd_data), 0);
      end
      rst_n = 1'b1;

      // Single channel, periodic scans
      ch_mask = 8'h04; enable = 1'b1; clr();
      wait_done(3, 400);
      check_seq("single", 8'h04);
      check("single_scans", 32'(addr_q.size()), 3);
      check("single_acks", 32'(ack_cnt), 3);
      check("single_dbl_ack", 32'(dbl_ack), 0);
      check("single_period1", (done_q.size() >= 3) ? 32'(done_q[1] - done_q[0]) : 32'hFFFF_FFFF, P);
      check("single_period2", (done_q.size() >= 3) ? 32'(done_q[2] - done_q[1]) : 32'hFFFF_FFFF, P);
      exp_sv = 8'h04;
      check_results("single_result", 8'h04);
      check("single_valid", 32'(sample_valid), 32'(exp_sv));
      check("single_overrun", 32'(overrun), 0);

      // Multi-channel ascending order, random latency
      quiet(); ch_mask = 8'h91; lat_lo = 1; lat_hi = 12; enable = 1'b1; clr();
      wait_done(1, 300);
      check_seq("multi", 8'h91);
      check("multi_gap", 32'(min_gap >= 2), 1);
      check("multi_addr_stable", 32'(addr_chg), 0);
      check("multi_dbl_ack", 32'(dbl_ack), 0);
      exp_sv |= 8'h91;
      check_results("multi_result", 8'h91);
      check("multi_valid", 32'(sample_valid), 32'(exp_sv));

      // Timeout on channel 1 after one good scan
      quiet(); ch_mask = 8'h03; enable = 1'b1; clr();
      wait_done(1, 300);
      exp_sv |= 8'h03;
      check("to_pre_valid", 32'(sample_valid), 32'(exp_sv));
      mute = 8'h02; clr();
      wait_done(1, 300);
      exp_sv &= ~8'h02;
      check_seq("to", 8'h03);
      check("to_count", 32'(to_cnt), 1);
      check("to_len", 32'(to_len), TO);
      check("to_ctl_drop", 32'(to_cv), 0);
      check("to_valid", 32'(sample_valid), 32'(exp_sv));
      check_results("to_keep_result", 8'h03);

      // Empty mask
      quiet(); mute = 8'd0; ch_mask = 8'h00; enable = 1'b1; clr();
      tk(5 * P);
      check("empty_requests", 32'(addr_q.size()), 0);
      check("empty_done", 32'(done_cnt), 0);
      check("empty_overrun", 32'(overrun), 0);

      // Overrun: eight slow channels exceed one period
      quiet(); ch_mask = 8'hFF; lat_lo = 10; lat_hi = 10; enable = 1'b1; clr();
      wait_done(1, 400);
      check_seq("ovr", 8'hFF);
      check("ovr_acks", 32'(ack_cnt), 8);
      check("ovr_flag", 32'(overrun), 1);
      exp_sv = 8'hFF;
      check("ovr_valid", 32'(sample_valid), 32'(exp_sv));
      check_results("ovr_result", 8'hFF);

      // Drop enable during channel 1 conversion
      quiet(); ch_mask = 8'h07; enable = 1'b1; clr();
      wait_cv(3'd1, 300);
      enable = 1'b0;
      tk(300);
      check("en_acks", 32'(ack_cnt), 2);
      check("en_requests", 32'(addr_q.size()), 2);
      check("en_no_done", 32'(done_cnt), 0);
      check("en_idle", 32'(adc.ctl_valid), 0);
      check_results("en_result", 8'h03);

      // Asynchronous reset mid-conversion
      ch_mask = 8'h01; enable = 1'b1; rd_addr = 3'd0; clr();
      wait_cv(3'd0, 300);
      #2 rst_n = 1'b0;
      #1;
      check("arst_ctl_valid", 32'(adc.ctl_valid), 0);
      check("arst_address", 32'(adc.address), 0);
      check("arst_adc_ack", 32'(adc.adc_ack), 0);
      check("arst_sample_valid", 32'(sample_valid), 0);
      check("arst_overrun", 32'(overrun), 0);
      check("arst_result", 32'(rd_data), 0);
      tk(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
